// File: rtl/mul_pipe_ctrl_if.sv
// Issue and writeback handshake bundle for the pipelined multiplier controller.
// The slave modport is the controller's view; master is the issue/writeback side.
interface mul_pipe_ctrl_if #(
    parameter int REG_W = 5
);
    logic             issue_valid;
    logic             issue_ready;
    logic [1:0]       issue_op;
    logic [REG_W-1:0] issue_rd;
    logic [REG_W-1:0] issue_rs1;
    logic [REG_W-1:0] issue_rs2;
    logic             wb_valid;
    logic             wb_ready;
    logic [REG_W-1:0] wb_rd;
    logic [1:0]       wb_op;

    modport slave (
        input  issue_valid, issue_op, issue_rd, issue_rs1, issue_rs2, wb_ready,
        output issue_ready, wb_valid, wb_rd, wb_op
    );

    modport master (
        output issue_valid, issue_op, issue_rd, issue_rs1, issue_rs2, wb_ready,
        input  issue_ready, wb_valid, wb_rd, wb_op
    );
endinterface

// File: rtl/mul_pipe_ctrl.sv
// Sequencing controller for the 3-stage multiplier (E -> M -> W): tracks per-stage
// valid/rd/op, drives stage load enables, stalls on writeback back-pressure and RAW hazards.
module mul_pipe_ctrl #(
    parameter int REG_W = 5,
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    mul_pipe_ctrl_if.slave   bus,
    input  logic             flush,
    output logic             en_M,
    output logic             en_W,
    output logic             hazard,
    output logic [1:0]       inflight,
    output logic [CNT_W-1:0] retired_cnt
);
    logic             r_valid_m;
    logic [REG_W-1:0] r_rd_m;
    logic [1:0]       r_op_m;
    logic             r_valid_w;
    logic [REG_W-1:0] r_rd_w;
    logic [1:0]       r_op_w;
    logic [CNT_W-1:0] r_retired_cnt;

    logic w_wb_fire;
    logic w_w_free;
    logic w_m_free;
    logic w_haz_m;
    logic w_haz_w;

    // NOTE: always_comb gives every output a default first so no path can infer a latch.
    always_comb begin
        w_wb_fire       = r_valid_w & bus.wb_ready;
        w_w_free        = !r_valid_w | bus.wb_ready;
        en_W            = r_valid_m & w_w_free & !flush;
        w_m_free        = !r_valid_m | en_W;
        w_haz_m         = r_valid_m && (r_rd_m != '0) &&
                          (r_rd_m == bus.issue_rs1 || r_rd_m == bus.issue_rs2);
        w_haz_w         = r_valid_w && (r_rd_w != '0) &&
                          (r_rd_w == bus.issue_rs1 || r_rd_w == bus.issue_rs2);
        hazard          = bus.issue_valid & (w_haz_m | w_haz_w);
        // Gated by rst_n so nothing is offered while the pipeline is held in reset.
        bus.issue_ready = rst_n & w_m_free & !hazard & !flush;
        en_M            = bus.issue_valid & bus.issue_ready;
    end

    assign bus.wb_valid = r_valid_w;
    assign bus.wb_rd    = r_rd_w;
    assign bus.wb_op    = r_op_w;
    assign inflight     = {1'b0, r_valid_m} + {1'b0, r_valid_w};
    assign retired_cnt  = r_retired_cnt;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid_m <= 1'b0;
            r_rd_m    <= '0;
            r_op_m    <= '0;
        end else if (flush) begin
            r_valid_m <= 1'b0;
        end else if (en_M) begin
            r_valid_m <= 1'b1;
            r_rd_m    <= bus.issue_rd;
            r_op_m    <= bus.issue_op;
        end else if (en_W) begin
            r_valid_m <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid_w <= 1'b0;
            r_rd_w    <= '0;
            r_op_w    <= '0;
        end else if (flush) begin
            r_valid_w <= 1'b0;
        end else if (en_W) begin
            r_valid_w <= 1'b1;
            r_rd_w    <= r_rd_m;
            r_op_w    <= r_op_m;
        end else if (w_wb_fire) begin
            r_valid_w <= 1'b0;
        end
    end

    // A writeback handshake in the flush cycle still completes and is counted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)         r_retired_cnt <= '0;
        else if (w_wb_fire) r_retired_cnt <= r_retired_cnt + 1'b1;
    end
endmodule

// File: tb/tb_mul_pipe_ctrl.sv
// Directed bench for mul_pipe_ctrl: hand-computed expectations checked by immediate assertions.
module tb_mul_pipe_ctrl;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush;
    logic        en_M, en_W, hazard;
    logic [1:0]  inflight;
    logic [31:0] retired_cnt;
    int          n_checks = 0;
    int          n_errors = 0;

    mul_pipe_ctrl_if #(.REG_W(5)) bus ();

    mul_pipe_ctrl #(.REG_W(5), .CNT_W(32)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus), .flush(flush),
        .en_M(en_M), .en_W(en_W), .hazard(hazard),
        .inflight(inflight), .retired_cnt(retired_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock edge; inputs change 1 time unit after the edge.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic v, input logic [1:0] op, input logic [4:0] rd,
                         input logic [4:0] rs1, input logic [4:0] rs2);
        bus.issue_valid = v;
        bus.issue_op    = op;
        bus.issue_rd    = rd;
        bus.issue_rs1   = rs1;
        bus.issue_rs2   = rs2;
    endtask

    initial begin
        rst_n = 1'b0;
        flush = 1'b0;
        bus.wb_ready = 1'b0;
        issue(1'b1, 2'd0, 5'd1, 5'd0, 5'd0);
        #2;
        check("rst_issue_ready", bus.issue_ready, 0);
        check("rst_en_M", en_M, 0);
        check("rst_wb_valid", bus.wb_valid, 0);
        check("rst_inflight", inflight, 0);
        check("rst_cnt", retired_cnt, 0);
        issue(1'b0, 2'd0, 5'd0, 5'd0, 5'd0);
        cyc(); cyc();
        rst_n = 1'b1;
        cyc();

        // 1: single MUL rd=5, two-cycle latency to wb_valid
        bus.wb_ready = 1'b1;
        issue(1'b1, 2'd0, 5'd5, 5'd2, 5'd3);
        #1;
        check("t1_ready", bus.issue_ready, 1);
        check("t1_en_M", en_M, 1);
        cyc();
        issue(1'b0, 2'd0, 5'd0, 5'd0, 5'd0);
        #1;
        check("t1_en_W", en_W, 1);
        check("t1_inflight", inflight, 1);
        check("t1_wb_early", bus.wb_valid, 0);
        cyc();
        #1;
        check("t1_wb_valid", bus.wb_valid, 1);
        check("t1_wb_rd", bus.wb_rd, 5);
        check("t1_cnt_before", retired_cnt, 0);
        cyc();
        #1;
        check("t1_cnt", retired_cnt, 1);
        check("t1_drained", bus.wb_valid, 0);

        // 2: back-to-back independent issues, simultaneous wb/en_W/en_M
        issue(1'b1, 2'd1, 5'd1, 5'd10, 5'd11);
        #1 check("t2_ready1", bus.issue_ready, 1);
        cyc();
        issue(1'b1, 2'd2, 5'd2, 5'd10, 5'd11);
        #1 check("t2_ready2", bus.issue_ready, 1);
        cyc();
        issue(1'b1, 2'd3, 5'd3, 5'd10, 5'd11);
        #1;
        check("t2_ready3", bus.issue_ready, 1);
        check("t2_wb_rd1", bus.wb_rd, 1);
        check("t2_en_W", en_W, 1);
        cyc();
        issue(1'b0, 2'd0, 5'd0, 5'd0, 5'd0);
        #1;
        check("t2_wb_rd2", bus.wb_rd, 2);
        check("t2_inflight_full", inflight, 2);
        cyc();
        #1;
        check("t2_wb_rd3", bus.wb_rd, 3);
        check("t2_wb_op3", bus.wb_op, 3);
        cyc();
        #1;
        check("t2_cnt", retired_cnt, 4);
        check("t2_idle", inflight, 0);

        // 3: writeback stall holds the pipeline, then drains in order
        bus.wb_ready = 1'b0;
        issue(1'b1, 2'd1, 5'd4, 5'd10, 5'd11);
        cyc();
        issue(1'b1, 2'd2, 5'd6, 5'd10, 5'd11);
        cyc();
        issue(1'b1, 2'd0, 5'd8, 5'd10, 5'd11);
        #1;
        check("t3_inflight", inflight, 2);
        check("t3_ready", bus.issue_ready, 0);
        check("t3_en_W", en_W, 0);
        cyc();
        issue(1'b0, 2'd0, 5'd0, 5'd0, 5'd0);
        #1;
        check("t3_wb_rd_hold", bus.wb_rd, 4);
        check("t3_wb_op_hold", bus.wb_op, 1);
        check("t3_inflight_hold", inflight, 2);
        bus.wb_ready = 1'b1;
        #1 check("t3_release_en_W", en_W, 1);
        cyc();
        #1;
        check("t3_wb_rd2", bus.wb_rd, 6);
        check("t3_wb_op2", bus.wb_op, 2);
        check("t3_cnt_mid", retired_cnt, 5);
        cyc();
        #1;
        check("t3_cnt", retired_cnt, 6);
        check("t3_idle", inflight, 0);

        // 4: RAW hazard on rd=7 until it retires; rd=0 never hazards
        issue(1'b1, 2'd3, 5'd7, 5'd1, 5'd2);
        cyc();
        issue(1'b1, 2'd0, 5'd9, 5'd7, 5'd0);
        #1;
        check("t4_hazard_M", hazard, 1);
        check("t4_ready_M", bus.issue_ready, 0);
        cyc();
        #1;
        check("t4_hazard_W", hazard, 1);
        check("t4_wb_rd7", bus.wb_rd, 7);
        cyc();
        #1;
        check("t4_hazard_clear", hazard, 0);
        check("t4_ready_clear", bus.issue_ready, 1);
        check("t4_cnt", retired_cnt, 7);
        cyc();
        issue(1'b1, 2'd0, 5'd0, 5'd12, 5'd13);
        #1 check("t4_ready_rd0", bus.issue_ready, 1);
        cyc();
        issue(1'b1, 2'd0, 5'd10, 5'd0, 5'd0);
        #1;
        check("t4_rd0_no_hazard", hazard, 0);
        check("t4_rd0_ready", bus.issue_ready, 1);
        cyc();
        issue(1'b0, 2'd0, 5'd0, 5'd0, 5'd0);
        #1;
        check("t4_rd0_wb_valid", bus.wb_valid, 1);
        check("t4_rd0_wb_rd", bus.wb_rd, 0);
        cyc(); cyc();
        #1;
        check("t4_cnt_end", retired_cnt, 10);
        check("t4_idle", inflight, 0);

        // 5: flush with M and W full; W retires, M is killed, no issue accepted
        bus.wb_ready = 1'b0;
        issue(1'b1, 2'd0, 5'd1, 5'd20, 5'd21);
        cyc();
        issue(1'b1, 2'd0, 5'd2, 5'd20, 5'd21);
        cyc();
        issue(1'b1, 2'd0, 5'd3, 5'd20, 5'd21);
        bus.wb_ready = 1'b1;
        flush = 1'b1;
        #1;
        check("t5_full", inflight, 2);
        check("t5_ready", bus.issue_ready, 0);
        check("t5_en_M", en_M, 0);
        check("t5_en_W", en_W, 0);
        cyc();
        flush = 1'b0;
        issue(1'b0, 2'd0, 5'd0, 5'd0, 5'd0);
        #1;
        check("t5_inflight", inflight, 0);
        check("t5_wb_valid", bus.wb_valid, 0);
        check("t5_cnt", retired_cnt, 11);
        cyc(); cyc();
        #1 check("t5_no_late_wb", bus.wb_valid, 0);

        // 6: async reset with two ops in flight
        bus.wb_ready = 1'b0;
        issue(1'b1, 2'd0, 5'd5, 5'd20, 5'd21);
        cyc();
        issue(1'b1, 2'd0, 5'd6, 5'd20, 5'd21);
        cyc();
        issue(1'b1, 2'd0, 5'd7, 5'd20, 5'd21);
        #1 check("t6_full", inflight, 2);
        rst_n = 1'b0;
        #1;
        check("t6_ready", bus.issue_ready, 0);
        check("t6_wb_valid", bus.wb_valid, 0);
        check("t6_inflight", inflight, 0);
        check("t6_cnt", retired_cnt, 0);
        check("t6_en_M", en_M, 0);
        check("t6_en_W", en_W, 0);
        issue(1'b0, 2'd0, 5'd0, 5'd0, 5'd0);
        bus.wb_ready = 1'b1;
        cyc();
        rst_n = 1'b1;
        cyc(); cyc();
        #1;
        check("t6_post_wb_valid", bus.wb_valid, 0);
        check("t6_post_inflight", inflight, 0);
        check("t6_post_cnt", retired_cnt, 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
